tt_um_ternary_mac: RTL and testbench

Ternary matrix-vector engine directly downstream of the weight loader. It consumes the loader's 16×8 array of 2-bit signed ternary weights plus its load-done pulse. It then accepts a vector of signed 8-bit activations one element per cycle, accumulates all output columns in parallel, and streams the accumulated results out one column per cycle.

---
 rtl/tt_um_ternary_mac.sv | 147 ++++++++++++++
 tb/tb_tt_um_ternary_mac.sv | 275 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/tt_um_ternary_mac.sv
// Ternary matrix-vector MAC: streams activations against a 16x8 ternary weight
// array, accumulates every column in parallel, then drains one column per cycle.
module tt_um_ternary_mac #(
   parameter int unsigned MaxInLen  = 16,
   parameter int unsigned MaxOutLen = 8,
   parameter int unsigned BitWidth  = 8,
   parameter int unsigned AccWidth  = BitWidth + $clog2(MaxInLen)
) (
   input  logic                       clk,
   input  logic                       rst_n,
   input  logic                       ena,
   input  logic signed [1:0]          ui_weights [MaxInLen][MaxOutLen],
   input  logic                       ui_load_done,
   input  logic [6:0]                 ui_param,
   input  logic signed [BitWidth-1:0] ui_act,
   input  logic                       ui_act_valid,
   output logic                       uo_ready,
   output logic signed [AccWidth-1:0] uo_out,
   output logic                       uo_valid
);

   localparam int unsigned InCntW  = $clog2(MaxInLen);
   localparam int unsigned OutCntW = $clog2(MaxOutLen);

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      SETTLE = 2'd1,
      ACCUM  = 2'd2,
      DRAIN  = 2'd3
   } state_t;

   state_t                      state;
   state_t                      state_next;
   logic [InCntW-1:0]           in_count;
   logic [OutCntW-1:0]          out_count;
   logic signed [AccWidth-1:0]  acc  [MaxOutLen];
   logic signed [AccWidth-1:0]  term [MaxOutLen];
   logic signed [AccWidth-1:0]  act_ext;
   logic [InCntW-1:0]           in_last;
   logic [OutCntW-1:0]          out_last;
   logic                        in_last_hit;
   logic                        out_last_hit;
   logic                        acc_clear;
   logic                        acc_step;
   logic                        drain_step;

   // ui_param is sampled live and held stable by the loader for the whole vector
   assign in_last      = InCntW'(ui_param[6:3]);
   assign out_last     = OutCntW'(ui_param[2:0]);
   assign in_last_hit  = (in_count == in_last);
   assign out_last_hit = (out_count == out_last);

   // Per-column contribution of the current activation; code 10 is treated as zero
   always_comb begin
      act_ext = AccWidth'(ui_act);
      for (int unsigned j = 0; j < MaxOutLen; j++) begin
         unique case (ui_weights[in_count][j])
            2'b01:   term[j] = act_ext;
            2'b11:   term[j] = -act_ext;
            default: term[j] = '0;
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= IDLE;
      end else begin
         state <= state_next;
      end
   end

   // Next state and datapath strobes; a load pulse overrides everything else
   always_comb begin
      state_next = state;
      acc_clear  = 1'b0;
      acc_step   = 1'b0;
      drain_step = 1'b0;
      uo_ready   = ena && (state == ACCUM);
      if (ena) begin
         if (ui_load_done) begin
            state_next = SETTLE;
         end else begin
            unique case (state)
               IDLE: begin
                  state_next = IDLE;
               end
               SETTLE: begin
                  state_next = ACCUM;
                  acc_clear  = 1'b1;
               end
               ACCUM: begin
                  if (ui_act_valid) begin
                     acc_step = 1'b1;
                     if (in_last_hit) begin
                        state_next = DRAIN;
                     end
                  end
               end
               DRAIN: begin
                  drain_step = 1'b1;
                  if (out_last_hit) begin
                     state_next = ACCUM;
                     acc_clear  = 1'b1;
                  end
               end
            endcase
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         in_count  <= '0;
         out_count <= '0;
         uo_out    <= '0;
         uo_valid  <= 1'b0;
         for (int unsigned j = 0; j < MaxOutLen; j++) begin
            acc[j] <= '0;
         end
      end else if (ena) begin
         uo_valid <= drain_step;
         if (drain_step) begin
            uo_out <= acc[out_count];
            if (!out_last_hit) begin
               out_count <= out_count + OutCntW'(1);
            end
         end
         if (acc_clear) begin
            in_count <= '0;
            for (int unsigned j = 0; j < MaxOutLen; j++) begin
               acc[j] <= '0;
            end
         end else if (acc_step) begin
            for (int unsigned j = 0; j < MaxOutLen; j++) begin
               acc[j] <= acc[j] + term[j];
            end
            if (in_last_hit) begin
               out_count <= '0;
            end else begin
               in_count <= in_count + InCntW'(1);
            end
         end
      end
   end

endmodule

// File: tb/tb_tt_um_ternary_mac.sv
// Directed bench for tt_um_ternary_mac: expected column sums are computed from the
// weights/activations and queued, then popped as each valid result appears.
module tb_tt_um_ternary_mac;

   logic                clk;
   logic                rst_n;
   logic                ena;
   logic signed [1:0]   w [16][8];
   logic                ui_load_done;
   logic [6:0]          ui_param;
   logic signed [7:0]   ui_act;
   logic                ui_act_valid;
   logic                uo_ready;
   logic signed [11:0]  uo_out;
   logic                uo_valid;

   int n_cmp = 0;
   int n_bad = 0;
   int sb[$];

   tt_um_ternary_mac dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .ena          (ena),
      .ui_weights   (w),
      .ui_load_done (ui_load_done),
      .ui_param     (ui_param),
      .ui_act       (ui_act),
      .ui_act_valid (ui_act_valid),
      .uo_ready     (uo_ready),
      .uo_out       (uo_out),
      .uo_valid     (uo_valid)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish, observed=timeout expected=finish");
      $fatal(1, "watchdog");
   end

   task automatic check(input string tag, input logic signed [31:0] obs,
                        input logic signed [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_bad++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   function automatic int wval(input logic [1:0] c);
      case (c)
         2'b01:   return 1;
         2'b11:   return -1;
         default: return 0;
      endcase
   endfunction

   // One clock; frozen outputs are checked when ena was low, results popped otherwise
   task automatic cyc();
      logic               e;
      logic               pv;
      logic signed [11:0] po;
      int                 x;
      e  = ena;
      pv = uo_valid;
      po = uo_out;
      @(posedge clk);
      #1;
      if (!e) begin
         check("hold_valid", uo_valid, pv);
         check("hold_out", uo_out, po);
      end else if (uo_valid) begin
         if (sb.size() == 0) begin
            check("spurious_valid", uo_valid, 0);
         end else begin
            x = sb.pop_front();
            check("result", uo_out, x);
            if (sb.size() == 0) check("ready_at_last", uo_ready, 1);
         end
      end
   endtask

   task automatic do_load();
      ena          = 1'b1;
      ui_act_valid = 1'b0;
      ui_load_done = 1'b1;
      cyc();
      ui_load_done = 1'b0;
      check("settle_ready", uo_ready, 0);
      check("settle_valid", uo_valid, 0);
      cyc();
      check("load_ready", uo_ready, 1);
   endtask

   task automatic run_vec(input int in_len, input int out_len, input int acts[$],
                          input bit gaps, input int stall_acc, input int stall_drn);
      int  e;
      int  total;
      int  guard;
      bit  stalled;
      ui_param = {4'(in_len - 1), 3'(out_len - 1)};
      for (int j = 0; j < out_len; j++) begin
         e = 0;
         for (int i = 0; i < in_len; i++) e += wval(w[i][j]) * acts[i];
         sb.push_back(e);
      end
      for (int i = 0; i < in_len; i++) begin
         if (i == stall_acc) begin
            ena          = 1'b0;
            ui_act_valid = 1'b1;
            ui_act       = 8'sd55;
            repeat (3) begin
               #1 check("stall_acc_ready", uo_ready, 0);
               cyc();
            end
            ena = 1'b1;
         end
         ui_act       = 8'(acts[i]);
         ui_act_valid = 1'b1;
         #1 check("accum_ready", uo_ready, 1);
         cyc();
         if (gaps && (i % 3 == 1) && (i != in_len - 1)) begin
            ui_act_valid = 1'b0;
            ui_act       = 8'sd77;
            cyc();
         end
      end
      ui_act       = 8'sd99;
      ui_act_valid = 1'b1;
      #1 check("drain_ready", uo_ready, 0);
      check("pre_drain_valid", uo_valid, 0);
      total   = sb.size();
      guard   = 0;
      stalled = 1'b0;
      while (sb.size() > 0 && guard < 200) begin
         if (!stalled && stall_drn >= 0 && (total - sb.size()) == stall_drn) begin
            stalled = 1'b1;
            ena     = 1'b0;
            repeat (3) begin
               #1 check("stall_drn_ready", uo_ready, 0);
               cyc();
            end
            ena = 1'b1;
         end else begin
            cyc();
            guard++;
            if (sb.size() > 0) check("valid_run", uo_valid, 1);
         end
      end
      ui_act_valid = 1'b0;
      if (sb.size() > 0) begin
         check("drain_timeout", sb.size(), 0);
         sb.delete();
      end
      cyc();
      check("valid_drop", uo_valid, 0);
      check("post_ready", uo_ready, 1);
   endtask

   initial begin
      int a[$];
      int b[$];
      rst_n        = 1'b0;
      ena          = 1'b0;
      ui_load_done = 1'b0;
      ui_param     = 7'h7F;
      ui_act       = '0;
      ui_act_valid = 1'b0;
      for (int i = 0; i < 16; i++)
         for (int j = 0; j < 8; j++) w[i][j] = 2'b00;

      #1;
      check("rst_out", uo_out, 0);
      check("rst_valid", uo_valid, 0);
      check("rst_ready", uo_ready, 0);
      repeat (2) @(posedge clk);
      #1 rst_n = 1'b1;
      ena = 1'b1;
      cyc();
      cyc();
      check("idle_ready", uo_ready, 0);

      // All +1 weights, activations 1..16
      for (int i = 0; i < 16; i++)
         for (int j = 0; j < 8; j++) w[i][j] = 2'b01;
      do_load();
      a.delete();
      for (int i = 1; i <= 16; i++) a.push_back(i);
      run_vec(16, 8, a, 1'b0, -1, -1);

      // All -1 weights, +127 then -127 back-to-back
      for (int i = 0; i < 16; i++)
         for (int j = 0; j < 8; j++) w[i][j] = 2'b11;
      do_load();
      a.delete();
      for (int i = 0; i < 16; i++) a.push_back(127);
      run_vec(16, 8, a, 1'b0, -1, -1);
      a.delete();
      for (int i = 0; i < 16; i++) a.push_back(-127);
      run_vec(16, 8, a, 1'b0, -1, -1);

      // Identity-like weights with illegal code 10 off-diagonal in row 15
      for (int i = 0; i < 16; i++)
         for (int j = 0; j < 8; j++)
            w[i][j] = (i == j) ? 2'b01 : ((i == 15) ? 2'b10 : 2'b00);
      do_load();
      a = '{5, -3, 7, 0, 9, 9, 9, 9};
      run_vec(8, 4, a, 1'b0, -1, -1);
      a.delete();
      for (int i = 0; i < 16; i++) a.push_back($urandom_range(0, 255) - 128);
      run_vec(16, 8, a, 1'b0, -1, -1);

      // Random ternary weights incl. code 10; same vector plain, then with gaps and stalls
      for (int i = 0; i < 16; i++)
         for (int j = 0; j < 8; j++) w[i][j] = 2'($urandom_range(0, 3));
      do_load();
      a.delete();
      for (int i = 0; i < 16; i++) a.push_back($urandom_range(0, 255) - 128);
      run_vec(16, 8, a, 1'b0, -1, -1);
      run_vec(16, 8, a, 1'b1, 6, 3);
      run_vec(5, 3, a, 1'b1, 0, 0);
      b = '{-100};
      run_vec(1, 1, b, 1'b0, -1, -1);

      // Reload abort after 5 activations
      do_load();
      ui_param = 7'h7F;
      for (int i = 0; i < 5; i++) begin
         ui_act       = 8'sd100;
         ui_act_valid = 1'b1;
         cyc();
      end
      ui_load_done = 1'b1;
      cyc();
      ui_load_done = 1'b0;
      ui_act_valid = 1'b0;
      check("abort_valid", uo_valid, 0);
      check("abort_settle_ready", uo_ready, 0);
      cyc();
      check("abort_ready", uo_ready, 1);
      a.delete();
      for (int i = 0; i < 16; i++) a.push_back($urandom_range(0, 255) - 128);
      run_vec(16, 8, a, 1'b0, -1, -1);

      // Asynchronous reset mid-accumulation
      check("pre_rst_out_nonzero", (uo_out != 0), 1);
      for (int i = 0; i < 3; i++) begin
         ui_act       = 8'sd50;
         ui_act_valid = 1'b1;
         cyc();
      end
      #2 rst_n = 1'b0;
      #1;
      check("arst_out", uo_out, 0);
      check("arst_valid", uo_valid, 0);
      check("arst_ready", uo_ready, 0);
      repeat (2) @(posedge clk);
      #1 rst_n = 1'b1;
      ui_act_valid = 1'b1;
      repeat (4) begin
         cyc();
         check("post_rst_ready", uo_ready, 0);
         check("post_rst_valid", uo_valid, 0);
      end
      do_load();
      run_vec(16, 8, a, 1'b0, -1, -1);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
